// File: rtl/mem_ctrl_16.sv
// mem_ctrl_16: 32-bit word requests to a 16-bit async SRAM bus, done as two half-word cycles.
// The even half-word holds bits[31:16] and the odd one bits[15:0] (big-endian).
// Every half-word access holds its strobe for WAIT_CYCLES+1 cycles.
// Optional feature macro: MEMCTL_WRPOST_EN. When it is defined, a write is acked one cycle
// after it is accepted, and the external cycle then finishes while req_busy stays high.
module mem_ctrl_16 #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk_25m,
    input  logic              reset_n,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_sel,
    input  logic              req_rd,
    input  logic              req_wr,
    output logic [31:0]       req_rdata,
    output logic              req_ack,
    output logic              req_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_dout,
    input  logic [15:0]       ram_din,
    output logic [1:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    localparam int unsigned WordW  = ADDR_W - 1;
    localparam logic [3:0]  WaitLd = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {StIdle, StAccHi, StGap, StAccLo, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WordW-1:0]   word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         sel_q, sel_d;
    logic               wr_q, wr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [15:0]        ram_dout_q, ram_dout_d;
    logic [1:0]         ram_be_n_q, ram_be_n_d;
    logic               ram_ce_n_q, ram_ce_n_d;
    logic               ram_oe_n_q, ram_oe_n_d;
    logic               ram_we_n_q, ram_we_n_d;

    // The bits above the word index and the byte offset are not used.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

    // Next-state logic. The RAM pins are registered, so they are decoded from state_d.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        ram_be_n_d = 2'b11;
        ram_ce_n_d = 1'b1;
        ram_oe_n_d = 1'b1;
        ram_we_n_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (req_wr || req_rd) begin
                    word_d  = req_addr[ADDR_W:2];
                    wdata_d = req_wdata;
                    sel_d   = req_sel;
                    wr_d    = req_wr;
                    cnt_d   = WaitLd;
                    if (req_wr) begin
                        // A write skips any half that has no byte enables set.
                        if (|req_sel[3:2]) begin
                            state_d = StAccHi;
                        end else if (|req_sel[1:0]) begin
                            state_d = StAccLo;
                        end else begin
                            state_d = StDone;
                        end
`ifdef MEMCTL_WRPOST_EN
                        ack_d = 1'b1;
`endif
                    end else begin
                        state_d = StAccHi;
                    end
                end
            end
            StAccHi: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        rdata_d[31:16] = ram_din;
                    end
                    state_d = (wr_q && (sel_q[1:0] == 2'b00)) ? StDone : StGap;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StGap: begin
                cnt_d   = WaitLd;
                state_d = StAccLo;
            end
            StAccLo: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        rdata_d[15:0] = ram_din;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The ack is registered, so it is high in the same cycles as StDone.
        if (state_d == StDone) begin
`ifdef MEMCTL_WRPOST_EN
            // A posted write has already been acked when it was accepted.
            if (!wr_d) begin
                ack_d = 1'b1;
            end
`else
            ack_d = 1'b1;
`endif
        end

        if (state_d == StAccHi) begin
            ram_addr_d = {word_d, 1'b0};
            ram_dout_d = wdata_d[31:16];
            ram_be_n_d = ~sel_d[3:2];
            ram_ce_n_d = 1'b0;
            ram_oe_n_d = wr_d;
            ram_we_n_d = ~wr_d;
        end else if (state_d == StAccLo) begin
            ram_addr_d = {word_d, 1'b1};
            ram_dout_d = wdata_d[15:0];
            ram_be_n_d = ~sel_d[1:0];
            ram_ce_n_d = 1'b0;
            ram_oe_n_d = wr_d;
            ram_we_n_d = ~wr_d;
        end
    end

    // State and output registers, with asynchronous reset.
    always_ff @(posedge clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            word_q     <= '0;
            wdata_q    <= 32'd0;
            sel_q      <= 4'd0;
            wr_q       <= 1'b0;
            rdata_q    <= 32'd0;
            ack_q      <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= 16'd0;
            ram_be_n_q <= 2'b11;
            ram_ce_n_q <= 1'b1;
            ram_oe_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            ram_be_n_q <= ram_be_n_d;
            ram_ce_n_q <= ram_ce_n_d;
            ram_oe_n_q <= ram_oe_n_d;
            ram_we_n_q <= ram_we_n_d;
        end
    end

    assign req_rdata = rdata_q;
    assign req_ack   = ack_q;
    assign req_busy  = (state_q != StIdle);
    assign ram_addr  = ram_addr_q;
    assign ram_dout  = ram_dout_q;
    assign ram_be_n  = ram_be_n_q;
    assign ram_ce_n  = ram_ce_n_q;
    assign ram_oe_n  = ram_oe_n_q;
    assign ram_we_n  = ram_we_n_q;

endmodule

// File: tb/tb_mem_ctrl_16.sv
// Testbench for mem_ctrl_16 with WAIT_CYCLES=1.
// A stimulus table is applied and checked against a queue-based scoreboard.
// Hand-written sequences cover reset in the middle of an access, the per-cycle strobe waveform,
// back-to-back reads, and a write followed by a read.
// Cycle numbering: a request is driven in cycle 0, and a read is acked in cycle 6.
module tb_mem_ctrl_16;

    localparam int unsigned AW = 20;

`ifdef MEMCTL_WRPOST_EN
    localparam int WL6 = 1;
    localparam int WL3 = 1;
    localparam int WL1 = 1;
`else
    localparam int WL6 = 6;
    localparam int WL3 = 3;
    localparam int WL1 = 1;
`endif

    logic          clk_25m;
    logic          reset_n;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_sel;
    logic          req_rd;
    logic          req_wr;
    logic [31:0]   req_rdata;
    logic          req_ack;
    logic          req_busy;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_dout;
    logic [15:0]   ram_din;
    logic [1:0]    ram_be_n;
    logic          ram_ce_n;
    logic          ram_oe_n;
    logic          ram_we_n;

    mem_ctrl_16 #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut (
        .clk_25m   (clk_25m),
        .reset_n   (reset_n),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_rdata (req_rdata),
        .req_ack   (req_ack),
        .req_busy  (req_busy),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .ram_be_n  (ram_be_n),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n)
    );

    initial clk_25m = 1'b0;
    always #20 clk_25m = ~clk_25m;

    int cyc = 0;
    always @(posedge clk_25m) cyc <= cyc + 1;

    // SRAM model. It is preloaded while reset is held low.
    logic [15:0] mem [8192];
    assign ram_din = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[12:0]] : 16'h0000;
    always @(posedge clk_25m) begin
        if (!reset_n) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 16'h0000;
            mem[13'h0800] <= 16'hDEAD;
            mem[13'h0801] <= 16'hBEEF;
            mem[13'h1000] <= 16'hAAAA;
            mem[13'h1001] <= 16'hAAAA;
        end else if (!ram_ce_n && !ram_we_n) begin
            if (!ram_be_n[1]) mem[ram_addr[12:0]][15:8] <= ram_dout[15:8];
            if (!ram_be_n[0]) mem[ram_addr[12:0]][7:0]  <= ram_dout[7:0];
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } ack_t;

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          lat;
        int          ce;
        logic [31:0] rdata;
    } vec_t;

    ack_t ack_q[$];
    exp_t exp_q[$];
    int   ce_cnt = 0;

    // Monitor: counts strobe cycles and records every ack.
    always @(negedge clk_25m) begin
        if (!ram_ce_n) ce_cnt <= ce_cnt + 1;
        if (req_ack) ack_q.push_back('{cyc, req_rdata});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic start_req(input vec_t v, output int ce_base);
        req_rd    = v.rd;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_sel   = v.sel;
        exp_q.push_back('{cyc, v.lat, v.rdata});
        ce_base = ce_cnt;
    endtask

    task automatic wait_ack(input string tag);
        int   n;
        ack_t a;
        exp_t e;
        n = 0;
        @(posedge clk_25m);
        while (ack_q.size() == 0 && n < 40) begin
            @(posedge clk_25m);
            n++;
        end
        if (ack_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s ack: got none, required one within 40 cycles", tag);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            a = ack_q.pop_front();
            $display("FAIL %s ack: got unexpected ack in cycle %0d, required none", tag, a.cyc);
        end else begin
            a = ack_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, " latency"}, 64'(a.cyc - e.start), 64'(e.lat));
            chk({tag, " rdata"}, 64'(a.rdata), 64'(e.rdata));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_25m);
        while (req_busy && n < 40) begin
            @(negedge clk_25m);
            n++;
        end
        chk({tag, " idle"}, 64'(req_busy), 64'(0));
    endtask

    task automatic drop_req();
        req_rd = 1'b0;
        req_wr = 1'b0;
    endtask

    vec_t vt[11];
    vec_t v;
    int   base;
    int   base2;

    // Expected {ce_n, we_n, be_n, dout, addr} for cycles 1..5 of a write with sel=4'b0110.
    logic [63:0] wave_exp[5];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'hF, 6,   4, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 1'b1, 32'h0000_2000, 32'h12345678,  4'h6, WL6, 4, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'hF, 6,   4, 32'hAA3456AA};
        vt[3]  = '{1'b0, 1'b1, 32'h0000_3000, 32'hCAFEF00D,  4'h3, WL3, 2, 32'hAA3456AA};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'hF, 6,   4, 32'h0000F00D};
        vt[5]  = '{1'b0, 1'b1, 32'h0000_3000, 32'hFFFFFFFF,  4'h0, WL1, 0, 32'h0000F00D};
        vt[6]  = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'hF, 6,   4, 32'h0000F00D};
        vt[7]  = '{1'b0, 1'b1, 32'h0000_3000, 32'h12349999,  4'hC, WL3, 2, 32'h0000F00D};
        vt[8]  = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'hF, 6,   4, 32'h1234F00D};
        vt[9]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h55667788,  4'h8, WL3, 2, 32'h1234F00D};
        vt[10] = '{1'b1, 1'b0, 32'hFFE0_1000, 32'h0,         4'hF, 6,   4, 32'h55ADBEEF};

        wave_exp[0] = {24'h0, 1'b0, 1'b0, 2'b10, 16'h1234, 20'h01000};
        wave_exp[1] = {24'h0, 1'b0, 1'b0, 2'b10, 16'h1234, 20'h01000};
        wave_exp[2] = {24'h0, 1'b1, 1'b1, 2'b11, 16'h1234, 20'h01000};
        wave_exp[3] = {24'h0, 1'b0, 1'b0, 2'b01, 16'h5678, 20'h01001};
        wave_exp[4] = {24'h0, 1'b0, 1'b0, 2'b01, 16'h5678, 20'h01001};

        reset_n   = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_sel   = 4'h0;
        repeat (3) @(posedge clk_25m);
        #1;
        chk("reset strobes", 64'({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}), 64'(5'b11111));
        chk("reset ack/busy", 64'({req_ack, req_busy}), 64'(0));
        chk("reset rdata/addr/dout", {req_rdata, 12'h0, ram_addr}, 64'(0));
        chk("reset dout", 64'(ram_dout), 64'(0));
        @(negedge clk_25m);
        reset_n = 1'b1;
        @(posedge clk_25m);
        #1;

        // Assert reset in the middle of ACC_LO. It must take effect without waiting for a clock edge.
        req_rd   = 1'b1;
        req_sel  = 4'hF;
        req_addr = 32'h0000_1000;
        repeat (4) @(posedge clk_25m);
        #10;
        chk("mid ACC_LO ce_n", 64'(ram_ce_n), 64'(0));
        reset_n = 1'b0;
        #1;
        chk("async reset strobes", 64'({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}), 64'(5'b11111));
        chk("async reset ack/busy", 64'({req_ack, req_busy}), 64'(0));
        chk("async reset rdata", 64'(req_rdata), 64'(0));
        req_rd = 1'b0;
        @(negedge clk_25m);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_25m);
        chk("post reset busy", 64'(req_busy), 64'(0));
        chk("post reset no ack", 64'(ack_q.size()), 64'(0));
        @(posedge clk_25m);
        #1;

        // Apply the stimulus table.
        for (int i = 0; i < 11; i++) begin
            start_req(vt[i], base);
            wait_ack($sformatf("vec%0d", i));
            #1;
            drop_req();
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d ce cycles", i), 64'(ce_cnt - base), 64'(vt[i].ce));
            @(posedge clk_25m);
            #1;
        end

        // Per-cycle waveform of a write with both halves partially enabled.
        v = '{1'b0, 1'b1, 32'h0000_2000, 32'h12345678, 4'h6, WL6, 4, 32'h55ADBEEF};
        start_req(v, base);
        @(negedge clk_25m);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_25m);
            chk($sformatf("wave cycle %0d", k + 1),
                {24'h0, ram_ce_n, ram_we_n, ram_be_n, ram_dout, ram_addr}, wave_exp[k]);
        end
        wait_ack("wave");
        #1;
        drop_req();
        wait_idle("wave");
        @(posedge clk_25m);
        #1;

        // Back-to-back reads. The second read is raised in the cycle right after the first ack.
        v = '{1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 6, 4, 32'h55ADBEEF};
        start_req(v, base);
        wait_ack("b2b first");
        #1;
        v = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 6, 4, 32'hAA3456AA};
        start_req(v, base2);
        wait_ack("b2b second");
        #1;
        drop_req();
        wait_idle("b2b");
        chk("b2b ce cycles", 64'(ce_cnt - base), 64'(8));
        @(posedge clk_25m);
        #1;

        // Write followed by a read. The read must be acked in cycle 13, counted from the write.
        // With write posting on, the read is only accepted after the write's ACC_LO has ended.
        v = '{1'b0, 1'b1, 32'h0000_2000, 32'h12345678, 4'h6, WL6, 4, 32'hAA3456AA};
        start_req(v, base);
        wait_ack("wr-rd write");
        #1;
        v = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 12 - WL6, 4, 32'h1234F00D};
        start_req(v, base2);
        wait_ack("wr-rd read");
        #1;
        drop_req();
        wait_idle("wr-rd");
        chk("wr-rd ce cycles", 64'(ce_cnt - base), 64'(8));

        repeat (3) @(negedge clk_25m);
        chk("no stray acks", 64'(ack_q.size()), 64'(0));
        chk("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
